clk_period_meter: RTL and testbench
===================================

CLK_PERIOD_METER -- requirements
Module: clk_period_meter

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of period/high-time counters and outputs.
REQ-002 Parameter TIMEOUT, default 65535: cycles without a rising edge before timeout; SHALL be >= 4 and <= 2^CNT_WIDTH-1.
REQ-003 i_clk_FPGA  input  1  sole clock; all state SHALL be on its rising edge.
REQ-004 i_reset  input  1  asynchronous, active-low reset.
REQ-005 i_clk_meas  input  1  divided clock under measurement; asynchronous to i_clk_FPGA, treated as data.
REQ-006 i_enable  input  1  high = measure; low = idle.
REQ-007 i_clear  input  1  single-cycle pulse; clears o_timeout.
REQ-008 o_period  output  CNT_WIDTH  last measured period in i_clk_FPGA cycles, rising edge to rising edge.
REQ-009 o_high_time  output  CNT_WIDTH  high-phase length of the same period, in i_clk_FPGA cycles.
REQ-010 o_valid  output  1  one-cycle pulse when o_period/o_high_time update.
REQ-011 o_timeout  output  1  sticky flag: no rising edge within TIMEOUT cycles.

Function
REQ-012 i_clk_meas SHALL pass through a 2-flop synchronizer plus a third delay flop; rise = sync2 & ~sync3, fall = ~sync2 & sync3.
REQ-013 Edge-detect latency SHALL be fixed: rise/fall asserts exactly 3 i_clk_FPGA cycles after the sampled input transition.
REQ-014 FSM states SHALL be IDLE, ARM, MEASURE.
REQ-015 IDLE: cnt = 0, high_cnt = 0; move to ARM when i_enable = 1.
REQ-016 ARM: wait for rise; on rise, cnt <= 1, move to MEASURE; no o_valid from ARM.
REQ-017 MEASURE: cnt increments by 1 each cycle, saturating at 2^CNT_WIDTH-1.
REQ-018 MEASURE, on fall: high_cnt <= cnt.
REQ-019 MEASURE, on rise: o_period <= cnt, o_high_time <= high_cnt, o_valid = 1 for that cycle, cnt <= 1, stay in MEASURE.
REQ-020 Result: a waveform with N-cycle period and H-cycle high phase SHALL give o_period = N, o_high_time = H.
REQ-021 Any period without a fall: o_high_time SHALL report the value latched at the last fall (stale value accepted).
REQ-022 ARM or MEASURE, when cnt (or the ARM wait counter) reaches TIMEOUT without a rise: o_timeout <= 1, cnt <= 0, go to ARM, no o_valid.
REQ-023 ARM SHALL use the same counter for its timeout; it counts from entry into ARM.
REQ-024 o_timeout SHALL stay set until i_clear = 1 or reset; if i_clear and a timeout occur in the same cycle, o_timeout SHALL be 1.
REQ-025 A rise in the same cycle as the timeout SHALL be processed as a rise; timeout SHALL NOT assert.
REQ-026 i_enable = 0 in any state: go to IDLE next cycle, with no o_valid that cycle; o_period, o_high_time and o_timeout SHALL hold.
REQ-027 Synchronizer flops SHALL run regardless of i_enable.
REQ-028 o_period and o_high_time SHALL change only in the cycle o_valid is asserted.

Reset
REQ-029 While i_reset = 0: state = IDLE, cnt = 0, high_cnt = 0, synchronizer flops = 0, o_period = 0, o_high_time = 0, o_valid = 0, o_timeout = 0.
REQ-030 Reset assertion mid-measurement SHALL discard the partial period; no o_valid on reset release.
REQ-031 After release, the first o_valid SHALL require a full ARM rise followed by a MEASURE rise.

Verification
REQ-032 Input high 5 and low 5 cycles, i_enable = 1 -> first o_valid at the 2nd detected rise; o_period = 10, o_high_time = 5; o_valid pulses every 10 cycles.
REQ-033 Input high 3 and low 7 cycles, then switched to high 8 and low 8 -> o_period = 10, o_high_time = 3; the first full new period reports o_period = 16, o_high_time = 8.
REQ-034 TIMEOUT = 64, input stuck low after one rise -> o_timeout = 1 exactly 64 cycles after the rise-processing cycle; o_valid stays 0; o_period holds its last value; i_clear -> o_timeout = 0 next cycle.
REQ-035 i_reset pulsed low mid-period on a divide-by-10 input -> all outputs 0 during reset; the first o_valid after release reports 10, not a partial count.
REQ-036 i_enable dropped for 20 cycles, then raised -> no o_valid while low; outputs hold; a fresh ARM-then-MEASURE sequence gives o_period = 10.
REQ-037 i_clear and a timeout in the same cycle -> o_timeout = 1.

Source files
------------

// File: rtl/clk_period_meter.sv
// Measures period and high time of a slow clock, sampled as data in the i_clk_FPGA domain.
// Latency: result registered on the cycle after a rise is seen 3 flops downstream of the input.
// Backpressure: none; o_valid is a one-cycle pulse and results hold until the next one.
module clk_period_meter #(
   parameter int CNT_WIDTH = 16,
   parameter int TIMEOUT   = 65535
) (
   input  logic                 i_clk_FPGA,
   input  logic                 i_reset,
   input  logic                 i_clk_meas,
   input  logic                 i_enable,
   input  logic                 i_clear,
   output logic [CNT_WIDTH-1:0] o_period,
   output logic [CNT_WIDTH-1:0] o_high_time,
   output logic                 o_valid,
   output logic                 o_timeout
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_ARM     = 2'd1,
      S_MEASURE = 2'd2
   } state_t;

   localparam logic [CNT_WIDTH-1:0] LP_TIMEOUT = CNT_WIDTH'(TIMEOUT);

   // r_sync[0..1] form the synchronizer, r_sync[2] is the edge-detect delay stage
   logic [2:0]           r_sync;
   state_t               r_state;
   logic [CNT_WIDTH-1:0] r_cnt;
   logic [CNT_WIDTH-1:0] r_high_cnt;
   logic [CNT_WIDTH-1:0] r_period;
   logic [CNT_WIDTH-1:0] r_high_time;
   logic                 r_valid;
   logic                 r_timeout;

   logic                 w_rise;
   logic                 w_fall;
   logic                 w_to_hit;
   logic [CNT_WIDTH-1:0] w_cnt_inc;
   state_t               w_state_nxt;
   logic [CNT_WIDTH-1:0] w_cnt_nxt;
   logic [CNT_WIDTH-1:0] w_high_cnt_nxt;
   logic [CNT_WIDTH-1:0] w_period_nxt;
   logic [CNT_WIDTH-1:0] w_high_time_nxt;
   logic                 w_valid_nxt;
   logic                 w_timeout_nxt;

   assign w_rise    = r_sync[1] & ~r_sync[2];
   assign w_fall    = ~r_sync[1] & r_sync[2];
   assign w_to_hit  = (r_cnt == LP_TIMEOUT);
   assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_WIDTH'(1);

   // Synchronizer and delay flop run continuously, independent of i_enable
   always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
      if (!i_reset) begin
         r_sync <= 3'b000;
      end else begin
         r_sync <= {r_sync[1:0], i_clk_meas};
      end
   end

   // FSM state register
   always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
      if (!i_reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state, counter and result logic; a rise always beats a coincident timeout
   always_comb begin
      w_state_nxt     = r_state;
      w_cnt_nxt       = r_cnt;
      w_high_cnt_nxt  = r_high_cnt;
      w_period_nxt    = r_period;
      w_high_time_nxt = r_high_time;
      w_valid_nxt     = 1'b0;
      w_timeout_nxt   = r_timeout & ~i_clear;

      if (!i_enable) begin
         w_state_nxt    = S_IDLE;
         w_cnt_nxt      = '0;
         w_high_cnt_nxt = '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               w_cnt_nxt      = '0;
               w_high_cnt_nxt = '0;
               w_state_nxt    = S_ARM;
            end
            S_ARM: begin
               if (w_rise) begin
                  w_cnt_nxt   = CNT_WIDTH'(1);
                  w_state_nxt = S_MEASURE;
               end else if (w_to_hit) begin
                  w_timeout_nxt = 1'b1;
                  w_cnt_nxt     = '0;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            S_MEASURE: begin
               if (w_fall) begin
                  w_high_cnt_nxt = r_cnt;
               end
               if (w_rise) begin
                  w_period_nxt    = r_cnt;
                  w_high_time_nxt = r_high_cnt;
                  w_valid_nxt     = 1'b1;
                  w_cnt_nxt       = CNT_WIDTH'(1);
               end else if (w_to_hit) begin
                  w_timeout_nxt = 1'b1;
                  w_cnt_nxt     = '0;
                  w_state_nxt   = S_ARM;
               end else begin
                  w_cnt_nxt = w_cnt_inc;
               end
            end
            default: begin
               w_state_nxt    = S_IDLE;
               w_cnt_nxt      = '0;
               w_high_cnt_nxt = '0;
            end
         endcase
      end
   end

   // Datapath and output registers
   always_ff @(posedge i_clk_FPGA or negedge i_reset) begin
      if (!i_reset) begin
         r_cnt       <= '0;
         r_high_cnt  <= '0;
         r_period    <= '0;
         r_high_time <= '0;
         r_valid     <= 1'b0;
         r_timeout   <= 1'b0;
      end else begin
         r_cnt       <= w_cnt_nxt;
         r_high_cnt  <= w_high_cnt_nxt;
         r_period    <= w_period_nxt;
         r_high_time <= w_high_time_nxt;
         r_valid     <= w_valid_nxt;
         r_timeout   <= w_timeout_nxt;
      end
   end

   assign o_period    = r_period;
   assign o_high_time = r_high_time;
   assign o_valid     = r_valid;
   assign o_timeout   = r_timeout;

endmodule

// File: tb/tb_clk_period_meter.sv
// Scoreboarded bench for clk_period_meter: random and directed waveforms on i_clk_meas,
// expected (period, high) pairs queued per input rise, monitor pops on o_valid.
// Directed phases cover reset, enable drop, waveform switch, timeout and clear/timeout overlap.
module tb_clk_period_meter;

   localparam int CW  = 16;
   localparam int TO  = 64;

   logic          clk;
   logic          i_reset;
   logic          i_clk_meas;
   logic          i_enable;
   logic          i_clear;
   logic [CW-1:0] o_period;
   logic [CW-1:0] o_high_time;
   logic          o_valid;
   logic          o_timeout;

   int errors = 0;
   int checks = 0;

   // scoreboard
   int exp_per[$];
   int exp_hi[$];

   // reference model state
   bit m_en        = 0;
   bit m_have_prev = 0;
   int m_prev_n    = 0;
   int m_prev_h    = 0;
   int m_last_p    = 0;
   int m_last_h    = 0;

   clk_period_meter #(.CNT_WIDTH(CW), .TIMEOUT(TO)) dut (
      .i_clk_FPGA (clk),
      .i_reset    (i_reset),
      .i_clk_meas (i_clk_meas),
      .i_enable   (i_enable),
      .i_clear    (i_clear),
      .o_period   (o_period),
      .o_high_time(o_high_time),
      .o_valid    (o_valid),
      .o_timeout  (o_timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // A rise of the measured clock completes the previous period, if the meter was measuring one
   task automatic note_rise(input int n, input int h);
      if (m_en) begin
         if (m_have_prev) begin
            exp_per.push_back(m_prev_n);
            exp_hi.push_back(m_prev_h);
         end
         m_have_prev = 1;
         m_prev_n    = n;
         m_prev_h    = h;
      end
   endtask

   // One period of n cycles, high for h cycles; call at a negedge
   task automatic gen_period(input int n, input int h);
      note_rise(n, h);
      i_clk_meas = 1'b1;
      repeat (h) @(negedge clk);
      i_clk_meas = 1'b0;
      repeat (n - h) @(negedge clk);
   endtask

   // Monitor: pops on o_valid, otherwise results must hold the last reported values
   always @(negedge clk) begin
      if (!i_reset) begin
         m_last_p = 0;
         m_last_h = 0;
      end else if (o_valid) begin
         if (exp_per.size() == 0) begin
            check("unexpected_valid", 1, 0);
         end else begin
            m_last_p = exp_per.pop_front();
            m_last_h = exp_hi.pop_front();
            check("period", int'(o_period), m_last_p);
            check("high_time", int'(o_high_time), m_last_h);
         end
      end else begin
         check("hold_period", int'(o_period), m_last_p);
         check("hold_high", int'(o_high_time), m_last_h);
      end
   end

   initial begin
      int n;
      int h;
      i_reset    = 1'b0;
      i_clk_meas = 1'b0;
      i_enable   = 1'b0;
      i_clear    = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_period", int'(o_period), 0);
      check("rst_high", int'(o_high_time), 0);
      check("rst_valid", int'(o_valid), 0);
      check("rst_timeout", int'(o_timeout), 0);
      i_reset = 1'b1;
      @(negedge clk);

      // divide-by-10, 50% duty, then random waveforms
      i_enable = 1'b1;
      m_en = 1; m_have_prev = 0;
      repeat (5) @(negedge clk);
      repeat (4) gen_period(10, 5);
      for (int i = 0; i < 25; i++) begin
         n = $urandom_range(60, 2);
         h = $urandom_range(n - 1, 1);
         gen_period(n, h);
      end

      // waveform switch 3/7 -> 8/8
      repeat (3) gen_period(10, 3);
      repeat (3) gen_period(16, 8);
      repeat (8) @(negedge clk);

      // enable dropped for 20 cycles while the input keeps toggling
      i_enable = 1'b0;
      m_en = 0; m_have_prev = 0;
      gen_period(10, 5);
      gen_period(10, 5);
      i_enable = 1'b1;
      m_en = 1;
      repeat (5) @(negedge clk);
      repeat (4) gen_period(10, 5);

      // reset pulsed mid-period
      note_rise(10, 5);
      i_clk_meas = 1'b1;
      repeat (5) @(negedge clk);
      i_clk_meas = 1'b0;
      repeat (2) @(negedge clk);
      i_reset = 1'b0;
      m_have_prev = 0;
      @(negedge clk);
      check("mid_rst_period", int'(o_period), 0);
      check("mid_rst_high", int'(o_high_time), 0);
      check("mid_rst_valid", int'(o_valid), 0);
      check("mid_rst_timeout", int'(o_timeout), 0);
      repeat (2) @(negedge clk);
      i_reset = 1'b1;
      repeat (3) @(negedge clk);
      repeat (4) gen_period(10, 5);

      // timeout: one rise then stuck low
      repeat (2) gen_period(10, 3);
      note_rise(0, 0);
      m_have_prev = 0;
      i_clk_meas = 1'b1;
      repeat (3) @(negedge clk);
      i_clk_meas = 1'b0;
      repeat (63) @(negedge clk);
      check("timeout_early", int'(o_timeout), 0);
      @(negedge clk);
      check("timeout_set", int'(o_timeout), 1);
      check("timeout_period_hold", int'(o_period), 10);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      check("timeout_cleared", int'(o_timeout), 0);
      repeat (63) @(negedge clk);
      check("arm_timeout_early", int'(o_timeout), 0);
      i_clear = 1'b1;
      @(negedge clk);
      i_clear = 1'b0;
      check("clear_vs_timeout", int'(o_timeout), 1);
      @(negedge clk);
      check("timeout_sticky", int'(o_timeout), 1);

      // every queued result must have been reported
      for (int i = 0; i < 200 && exp_per.size() != 0; i++) @(negedge clk);
      check("queue_drained", exp_per.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
